// File: rtl/cpu_pkg.sv
// Shared cpu-wide constants and the fetch buffer entry type.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   XLEN, INSTR_BYTES      architectural word width and instruction size
//   DEFAULT_RESET_PC       default first fetch address after reset
//   xword_t                one architectural word
//   fetch_entry_t          {pc, instr} pair held by the fetch buffer
//   align_pc()             clears the sub-instruction offset bits of an address
package cpu_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [XLEN-1:0] xword_t;

  // pc is the address the instruction word was fetched from.
  typedef struct packed {
    xword_t pc;
    xword_t instr;
  } fetch_entry_t;

  // Fetch addresses are always instruction aligned; low offset bits are dropped.
  function automatic xword_t align_pc(input xword_t pc);
    return pc & ~xword_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch instruction buffer: DEPTH-entry circular FIFO of {pc, instr} with flush.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: pushes into a full buffer are dropped (the fetch stage never issues
//   one), pops of an empty buffer are ignored; flush overrides push and pop.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 empty the buffer at the end of this cycle
//   push, push_entry      write one entry at the tail
//   pop                   retire the head entry
//   head_valid/head_entry registered head, entry forced to zero while empty
//   count                 current occupancy, 0..DEPTH
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output logic                     head_valid,
  output fetch_entry_t             head_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_pop  = pop & (count != '0) & ~flush;
  assign do_push = push & ~flush & ((count != FULL) | do_pop);

  assign head_valid = (count != '0);
  assign head_entry = head_valid ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head_entry is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_entry;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential fetch with redirect, feeding a small buffer.
// Latency: inst_valid two cycles after the matching imem_req; one instr/cycle sustained.
// Backpressure: inst_valid/inst_ready handshake; imem_req is withheld whenever the
//   buffer plus the in-flight request would exceed DEPTH.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req, imem_addr          fetch request and word-aligned address
//   imem_rdata                   instruction word, one cycle after its request
//   redirect_valid, redirect_pc  branch/jump redirect from the cpu
//   inst_valid, inst_ready       head handshake towards the cpu
//   inst_data, inst_pc           head instruction and its fetch address
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  // One extra bit so occupancy + inflight cannot wrap before the compare.
  localparam int SW = CW + 1;

  xword_t       fetch_pc;
  xword_t       inflight_pc;
  logic         inflight;

  logic         fifo_valid;
  fetch_entry_t fifo_head;
  fetch_entry_t resp_entry;
  logic [CW-1:0] fifo_count;

  logic         pop;
  logic         resp_push;
  logic [SW-1:0] committed;

  // Outputs are masked during reset so the cpu sees an empty stage from the first
  // reset cycle, before the registered state has actually been cleared.
  assign inst_valid = fifo_valid & ~rst;
  assign inst_data  = inst_valid ? fifo_head.instr : '0;
  assign inst_pc    = inst_valid ? fifo_head.pc    : '0;

  assign pop = inst_valid & inst_ready;

  // Slots already claimed next cycle: buffered entries plus the outstanding
  // response, minus the head leaving now. pop implies count >= 1, so no underflow.
  assign committed = SW'(fifo_count) + SW'(inflight) - SW'(pop);

  assign imem_req  = ~rst & ~redirect_valid & (committed < SW'(DEPTH));
  assign imem_addr = fetch_pc;

  // A response landing in a redirect cycle belongs to the old path and is dropped.
  assign resp_push        = inflight & ~redirect_valid;
  assign resp_entry.pc    = inflight_pc;
  assign resp_entry.instr = imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= align_pc(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        // 32-bit add wraps FFFF_FFFC -> 0000_0000.
        fetch_pc    <= fetch_pc + XLEN'(INSTR_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (resp_push),
    .push_entry (resp_entry),
    .pop        (pop),
    .head_valid (fifo_valid),
    .head_entry (fifo_head),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_addr_q[$];

  // Memory content is derived from the address so data and pc mix-ups show up.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hBAD0_BAD0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Program order from a new start address: fetch addresses and delivered pcs.
  task automatic seed_stream(input logic [31:0] start);
    logic [31:0] a;
    exp_pc_q.delete();
    exp_addr_q.delete();
    a = start & 32'hFFFF_FFFC;
    for (int i = 0; i < 96; i++) begin
      exp_pc_q.push_back(a);
      exp_addr_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Monitor: compares every request and every delivery against the queues.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc   = '0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst || redirect_valid) begin
      check("req_quiet", {31'b0, imem_req}, 32'd0);
    end else if (imem_req) begin
      if (exp_addr_q.size() == 0) check("addr_q_empty", 32'd1, 32'd0);
      else check("imem_addr", imem_addr, exp_addr_q.pop_front());
    end
    if (prev_hold && !rst) begin
      check("hold_valid", {31'b0, inst_valid}, 32'd1);
      check("hold_pc", inst_pc, prev_pc);
      check("hold_data", inst_data, prev_data);
    end
    if (inst_valid && inst_ready && !redirect_valid && !rst) begin
      if (exp_pc_q.size() == 0) begin
        check("pc_q_empty", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_pc_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_data", inst_data, mem_word(e));
      end
      n_deliv++;
    end
    prev_hold <= inst_valid && !inst_ready && !redirect_valid && !rst;
    prev_pc   <= inst_pc;
    prev_data <= inst_data;
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    seed_stream(RPC);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    seed_stream(target);
  endtask

  task automatic step();
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] targets [4] = '{32'h1000_0003, 32'h0000_0040, 32'hFFFF_FFF0, 32'h8000_0001};

  initial begin
    int req_cnt;
    int since;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    seed_stream(RPC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);

    // First fetches after reset release, ready held high.
    @(posedge clk); #1;
    rst = 1'b0;
    seed_stream(RPC);
    @(negedge clk);
    check("c0_req", {31'b0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, RPC);
    check("c0_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    check("c1_addr", imem_addr, RPC + 32'd4);
    check("c1_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    check("c2_valid", {31'b0, inst_valid}, 32'd1);
    check("c2_pc", inst_pc, RPC);
    @(negedge clk);
    check("c3_pc", inst_pc, RPC + 32'd4);
    @(negedge clk);
    check("c4_pc", inst_pc, RPC + 32'd8);
    repeat (6) step();

    // Stall from reset: only two requests fit in a two-entry buffer.
    inst_ready = 1'b0;
    do_reset(2);
    req_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req) req_cnt++;
    end
    check("stall_reqs", req_cnt, 32'd2);
    check("stall_valid", {31'b0, inst_valid}, 32'd1);
    check("stall_pc", inst_pc, RPC);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    repeat (20) step();

    // Redirect to an unaligned target while the buffer is full.
    inst_ready = 1'b0;
    repeat (4) step();
    redirect_to(32'h0000_0103);
    step();
    @(negedge clk);
    check("rd_addr", imem_addr, 32'h0000_0100);
    check("rd_flushed", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    check("rd_valid_r2", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    check("rd_valid_r3", {31'b0, inst_valid}, 32'd1);
    check("rd_pc_r3", inst_pc, 32'h0000_0100);
    @(posedge clk); #1;
    inst_ready = 1'b1;
    repeat (10) step();

    // Redirect mid-stream with a response in flight; fetch wraps through zero.
    redirect_to(32'hFFFF_FFF8);
    step();
    @(negedge clk);
    check("wrap_a0", imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_a1", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_a2", imem_addr, 32'h0000_0000);
    check("wrap_pc0", inst_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_pc1", inst_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc2", inst_pc, 32'h0000_0000);
    repeat (4) step();

    // Back-to-back redirects: the second target wins.
    redirect_to(32'h0000_0200);
    redirect_to(32'h0000_0300);
    step();
    @(negedge clk);
    check("b2b_addr", imem_addr, 32'h0000_0300);
    @(negedge clk);
    @(negedge clk);
    check("b2b_pc", inst_pc, 32'h0000_0300);
    repeat (8) step();

    // One-cycle reset pulse mid-stream.
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rp_valid_in_rst", {31'b0, inst_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seed_stream(RPC);
    @(negedge clk);
    check("rp_valid_after", {31'b0, inst_valid}, 32'd0);
    check("rp_req", {31'b0, imem_req}, 32'd1);
    check("rp_addr", imem_addr, RPC);
    repeat (10) step();

    // Random ready and redirects against the program-order scoreboard.
    since = 0;
    repeat (2000) begin
      @(posedge clk); #1;
      inst_ready = ($urandom_range(0, 3) != 0);
      since++;
      if (since >= 30 || $urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = targets[$urandom_range(0, 3)];
        seed_stream(redirect_pc);
        since = 0;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    step();
    repeat (3) step();
    check("deliveries", {31'b0, n_deliv > 500}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
